// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Tuse/Tnew codes, forwarding select encodings, the per-stage slot record,
// and the saturating Tnew decrement used as slots advance.
package hazard_pkg;

   localparam int TNEW_W = 2;

   localparam logic [TNEW_W-1:0] TUSE_NONE = 2'd3;

   localparam logic [TNEW_W-1:0] TNEW_LINK = 2'd0;
   localparam logic [TNEW_W-1:0] TNEW_ALU  = 2'd1;
   localparam logic [TNEW_W-1:0] TNEW_LOAD = 2'd2;

   // ID-stage operand sources
   localparam logic [1:0] SEL_GRF = 2'd0;
   localparam logic [1:0] SEL_E   = 2'd1;
   localparam logic [1:0] SEL_M   = 2'd2;
   localparam logic [1:0] SEL_W   = 2'd3;

   // EX-stage operand sources
   localparam logic [1:0] EX_SEL_IDEX = 2'd0;
   localparam logic [1:0] EX_SEL_M    = 2'd1;
   localparam logic [1:0] EX_SEL_W    = 2'd2;

   typedef struct packed {
      logic [4:0]        dst;
      logic [TNEW_W-1:0] tnew;
   } slot_t;

   localparam slot_t SLOT_BUBBLE = '{dst: 5'd0, tnew: '0};

   function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
      return (t == '0) ? '0 : t - 1'b1;
   endfunction

endpackage

// File: rtl/hazard_source_check.sv
// Hazard check for one source operand against three producer slots.
// slots_i[0] is the youngest producer; select code for a hit in slot i is i+1,
// which lines up with both the ID encoding (E/M/W) and the EX encoding (M/W).
// Optional feature macro: HAZARD_FORWARD_EN (forwarding + Tnew-aware stalls).
module hazard_source_check
   import hazard_pkg::*;
(
   input  logic [4:0]        src_addr_i,
   input  logic [TNEW_W-1:0] tuse_i,
   input  slot_t [2:0]       slots_i,
   output logic              stall_o,
   output logic [1:0]        sel_o
);

   logic [2:0] hit;

   // Address match per slot; register 0 never carries a dependency
   always_comb begin
      hit = '0;
      for (int i = 0; i < 3; i++)
         hit[i] = (src_addr_i != 5'd0) && (src_addr_i == slots_i[i].dst);
   end

`ifdef HAZARD_FORWARD_EN
   // Stall while a slot 0/1 producer is later than the use; forward from the youngest hit
   always_comb begin
      stall_o = 1'b0;
      sel_o   = SEL_GRF;
      for (int i = 0; i < 2; i++)
         if (hit[i] && (slots_i[i].tnew > tuse_i))
            stall_o = 1'b1;
      // walk oldest to youngest so the youngest hit decides, even when it is not ready yet
      for (int i = 2; i >= 0; i--)
         if (hit[i])
            sel_o = (slots_i[i].tnew == '0) ? 2'(i + 1) : SEL_GRF;
   end
`else
   // Without forwarding any slot 0/1 producer blocks a real use; older results come via GRF write-through
   always_comb begin
      stall_o = (|hit[1:0]) && (tuse_i != TUSE_NONE);
      sel_o   = SEL_GRF;
   end
`endif

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller for the five-stage core: tracks dst/Tnew of the
// instructions in E, M and W, drives stall and all forwarding selects.
// Optional feature macro: HAZARD_FORWARD_EN (undefined: selects tied to 0,
// any E/M match stalls).
module hazard_controller
   import hazard_pkg::*;
#(
   parameter int TW = 2
)
(
   input  logic          clk,
   input  logic          reset,
   input  logic [4:0]    id_rs_addr,
   input  logic [4:0]    id_rt_addr,
   input  logic [TW-1:0] id_rs_tuse,
   input  logic [TW-1:0] id_rt_tuse,
   input  logic [4:0]    id_dst_addr,
   input  logic [TW-1:0] id_tnew,
   output logic          stall,
   output logic [1:0]    id_fwd_rs_sel,
   output logic [1:0]    id_fwd_rt_sel,
   output logic [1:0]    ex_fwd_rs_sel,
   output logic [1:0]    ex_fwd_rt_sel
);

   slot_t      e_q, e_d, m_q, m_d, w_q, w_d;
   logic [4:0] e_rs_q, e_rs_d, e_rt_q, e_rt_d;
   logic       id_rs_stall, id_rt_stall, ex_rs_stall, ex_rt_stall;

   // Next slot contents: ID enters E unless stalled (bubble), older slots age by one
   always_comb begin
      e_d    = SLOT_BUBBLE;
      e_rs_d = 5'd0;
      e_rt_d = 5'd0;
      if (!stall) begin
         e_d    = '{dst: id_dst_addr, tnew: id_tnew};
         e_rs_d = id_rs_addr;
         e_rt_d = id_rt_addr;
      end
      m_d = '{dst: e_q.dst, tnew: tnew_dec(e_q.tnew)};
      w_d = '{dst: m_q.dst, tnew: tnew_dec(m_q.tnew)};
   end

   // Slot registers with synchronous clear
   always_ff @(posedge clk) begin
      if (reset) begin
         e_q    <= SLOT_BUBBLE;
         m_q    <= SLOT_BUBBLE;
         w_q    <= SLOT_BUBBLE;
         e_rs_q <= 5'd0;
         e_rt_q <= 5'd0;
      end else begin
         e_q    <= e_d;
         m_q    <= m_d;
         w_q    <= w_d;
         e_rs_q <= e_rs_d;
         e_rt_q <= e_rt_d;
      end
   end

   hazard_source_check u_id_rs (
      .src_addr_i (id_rs_addr),
      .tuse_i     (id_rs_tuse),
      .slots_i    ({w_q, m_q, e_q}),
      .stall_o    (id_rs_stall),
      .sel_o      (id_fwd_rs_sel)
   );

   hazard_source_check u_id_rt (
      .src_addr_i (id_rt_addr),
      .tuse_i     (id_rt_tuse),
      .slots_i    ({w_q, m_q, e_q}),
      .stall_o    (id_rt_stall),
      .sel_o      (id_fwd_rt_sel)
   );

   // EX consumers see only M and W; the third slot is a permanent bubble
   hazard_source_check u_ex_rs (
      .src_addr_i (e_rs_q),
      .tuse_i     (TUSE_NONE),
      .slots_i    ({SLOT_BUBBLE, w_q, m_q}),
      .stall_o    (ex_rs_stall),
      .sel_o      (ex_fwd_rs_sel)
   );

   hazard_source_check u_ex_rt (
      .src_addr_i (e_rt_q),
      .tuse_i     (TUSE_NONE),
      .slots_i    ({SLOT_BUBBLE, w_q, m_q}),
      .stall_o    (ex_rt_stall),
      .sel_o      (ex_fwd_rt_sel)
   );

   // EX checks run with TUSE_NONE so their stall terms are always 0
   assign stall = id_rs_stall | id_rt_stall | ex_rs_stall | ex_rt_stall;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus random
// instruction streams against an instruction-history reference model.
module tb_hazard_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] id_rs_addr, id_rt_addr, id_dst_addr;
   logic [1:0] id_rs_tuse, id_rt_tuse, id_tnew;
   logic       stall;
   logic [1:0] id_fwd_rs_sel, id_fwd_rt_sel, ex_fwd_rs_sel, ex_fwd_rt_sel;

   hazard_controller #(.TW(2)) dut (
      .clk           (clk),
      .reset         (reset),
      .id_rs_addr    (id_rs_addr),
      .id_rt_addr    (id_rt_addr),
      .id_rs_tuse    (id_rs_tuse),
      .id_rt_tuse    (id_rt_tuse),
      .id_dst_addr   (id_dst_addr),
      .id_tnew       (id_tnew),
      .stall         (stall),
      .id_fwd_rs_sel (id_fwd_rs_sel),
      .id_fwd_rt_sel (id_fwd_rt_sel),
      .ex_fwd_rs_sel (ex_fwd_rs_sel),
      .ex_fwd_rt_sel (ex_fwd_rt_sel)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] rs, rt, dst;
      int         rsu, rtu, tn;
   } instr_t;

   typedef struct {
      logic       stall;
      logic [1:0] idrs, idrt, exrs, exrt;
   } exp_t;

   exp_t   exp_q[$];
   instr_t pipe[3];   // instructions currently in E (0), M (1), W (2)
   int     vectors = 0;
   int     miscompares = 0;

   function automatic instr_t mk(input int rs, input int rsu, input int rt, input int rtu,
                                 input int dst, input int tn);
      instr_t r;
      r.rs = 5'(rs); r.rsu = rsu; r.rt = 5'(rt); r.rtu = rtu; r.dst = 5'(dst); r.tn = tn;
      return r;
   endfunction

   // cycles still needed before the result exists, for the instruction k stages past E
   function automatic int rem(input int k);
      return (pipe[k].tn > k) ? pipe[k].tn - k : 0;
   endfunction

   function automatic logic id_stall(input logic [4:0] a, input int u);
      if (a == 5'd0) return 1'b0;
      for (int k = 0; k < 2; k++)
         if (pipe[k].dst == a) begin
`ifdef HAZARD_FORWARD_EN
            if (rem(k) > u) return 1'b1;
`else
            if (u != 3) return 1'b1;
`endif
         end
      return 1'b0;
   endfunction

   function automatic logic [1:0] id_sel(input logic [4:0] a);
`ifdef HAZARD_FORWARD_EN
      if (a != 5'd0)
         for (int k = 0; k < 3; k++)
            if (pipe[k].dst == a) return (rem(k) == 0) ? 2'(k + 1) : 2'd0;
`endif
      return 2'd0;
   endfunction

   function automatic logic [1:0] ex_sel(input logic [4:0] a);
`ifdef HAZARD_FORWARD_EN
      if (a != 5'd0)
         for (int k = 1; k < 3; k++)
            if (pipe[k].dst == a) return (rem(k) == 0) ? 2'(k) : 2'd0;
`endif
      return 2'd0;
   endfunction

   // one cycle: drive ID, predict outputs, then advance the model across the edge
   task automatic step(input logic rst, input instr_t in, output logic st);
      exp_t e;
      reset       = rst;
      id_rs_addr  = in.rs;
      id_rt_addr  = in.rt;
      id_rs_tuse  = 2'(in.rsu);
      id_rt_tuse  = 2'(in.rtu);
      id_dst_addr = in.dst;
      id_tnew     = 2'(in.tn);
      e.stall = id_stall(in.rs, in.rsu) | id_stall(in.rt, in.rtu);
      e.idrs  = id_sel(in.rs);
      e.idrt  = id_sel(in.rt);
      e.exrs  = ex_sel(pipe[0].rs);
      e.exrt  = ex_sel(pipe[0].rt);
      exp_q.push_back(e);
      st = e.stall;
      @(posedge clk);
      if (rst) begin
         for (int k = 0; k < 3; k++) pipe[k] = mk(0, 3, 0, 3, 0, 0);
      end else begin
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = e.stall ? mk(0, 3, 0, 3, 0, 0) : in;
      end
      #1;
   endtask

   // hold an instruction in ID until the model says it moves on
   task automatic issue(input instr_t in);
      logic st;
      int   n = 0;
      do begin
         step(1'b0, in, st);
         n++;
      end while (st && n < 8);
   endtask

   task automatic chk(input string name, input logic [1:0] act, input logic [1:0] req);
      if (act !== req) begin
         $display("FAIL %s: got %0d, required %0d at t=%0t", name, act, req, $time);
         miscompares++;
      end
   endtask

   // monitor: outputs are presented every cycle; compare mid-cycle
   always @(negedge clk) begin : monitor
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vectors++;
         chk("stall", {1'b0, stall}, {1'b0, e.stall});
         chk("id_fwd_rs_sel", id_fwd_rs_sel, e.idrs);
         chk("id_fwd_rt_sel", id_fwd_rt_sel, e.idrt);
         chk("ex_fwd_rs_sel", ex_fwd_rs_sel, e.exrs);
         chk("ex_fwd_rt_sel", ex_fwd_rt_sel, e.exrt);
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   instr_t nop, r;
   logic   st;

   initial begin
      nop = mk(0, 3, 0, 3, 0, 0);
      for (int k = 0; k < 3; k++) pipe[k] = nop;
      reset = 1'b1;
      id_rs_addr = '0; id_rt_addr = '0; id_dst_addr = '0;
      id_rs_tuse = 2'd3; id_rt_tuse = 2'd3; id_tnew = '0;
      repeat (2) @(posedge clk);
      #1;

      // ALU writes $3, beq reads $3
      issue(mk(1, 1, 2, 1, 3, 1));
      issue(mk(3, 0, 0, 0, 0, 0));
      repeat (3) issue(nop);
      // load writes $5, addu reads $5
      issue(mk(29, 1, 0, 3, 5, 2));
      issue(mk(5, 1, 6, 1, 7, 1));
      repeat (3) issue(nop);
      // jal then jr $31
      issue(mk(0, 3, 0, 3, 31, 0));
      issue(mk(31, 0, 0, 3, 0, 0));
      repeat (3) issue(nop);
      // $0 everywhere
      repeat (3) issue(mk(0, 0, 0, 0, 0, 1));
      issue(mk(0, 0, 0, 0, 0, 0));
      repeat (3) issue(nop);
      // ALU writes $4, addu reads $4 on both rs and rt
      issue(mk(1, 1, 2, 1, 4, 1));
      issue(mk(4, 1, 4, 1, 8, 1));
      repeat (3) issue(nop);
      // reset while a load-use stall is pending
      issue(mk(29, 1, 0, 3, 5, 2));
      step(1'b1, mk(5, 0, 5, 0, 9, 1), st);
      step(1'b0, mk(5, 0, 5, 0, 9, 1), st);
      repeat (2) issue(nop);

      for (int blk = 0; blk < 4; blk++) begin
         for (int i = 0; i < 80; i++) begin
            r = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            issue(r);
         end
         // reset with random contents in all slots, then probe the emptied pipe
         r = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         step(1'b1, r, st);
         r = mk($urandom_range(1, 3), 0, $urandom_range(1, 3), 0, $urandom_range(0, 3), 1);
         issue(r);
      end
      repeat (3) issue(nop);

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
         miscompares++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
